// File: rtl/instruction_issuer.sv
// rtl/instruction_issuer.sv - program memory plus valid/complete handshake issuer with watchdog
//
// Purpose: holds a loadable program and presents one instruction at a time to the
// core, advancing only after completeInstruction (or a watchdog expiry).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   loadEn/loadAddr/loadData  program memory write port (accepted in IDLE only)
//   start, stop           begin issuing from address 0 / end after the in-flight instruction
//   loopMode, lastAddr    program end address and wrap behaviour
//   completeInstruction   retire pulse from the core
//   instruction           held instruction word, validInstruction marks a new one
//   busy, done, pc        status
//   issuedCount, timeoutCount, timeoutFlag  statistics
module instruction_issuer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [31:0]       loadData,
    input  logic              start,
    input  logic              stop,
    input  logic              loopMode,
    input  logic [ADDR_W-1:0] lastAddr,
    input  logic              completeInstruction,
    output logic [31:0]       instruction,
    output logic              validInstruction,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       issuedCount,
    output logic [15:0]       timeoutCount,
    output logic              timeoutFlag
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int TIMER_W = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]         state;
    logic [31:0]        mem [DEPTH];
    logic [TIMER_W-1:0] timer;
    logic               stopPending;

    logic [ADDR_W-1:0]  nextPc;
    logic               timerExpired;
    logic               endInstr;
    logic               timeoutHit;

    assign validInstruction = (state == ISSUE);
    assign busy             = (state == ISSUE) || (state == WAIT);
    assign done             = (state == DONE);

    assign nextPc       = (pc == lastAddr) ? '0 : pc + 1'b1;
    assign timerExpired = (timer == TIMER_W'(TIMEOUT - 1));
    assign endInstr     = (state == WAIT) && (completeInstruction || timerExpired);
    // A complete arriving on the expiry cycle wins: the core did retire it.
    assign timeoutHit   = timerExpired && !completeInstruction;

    // Program memory has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (loadEn && state == IDLE) begin
            mem[loadAddr] <= loadData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            instruction  <= '0;
            issuedCount  <= '0;
            timeoutCount <= '0;
            timeoutFlag  <= 1'b0;
            stopPending  <= 1'b0;
            timer        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        pc          <= '0;
                        instruction <= mem[{ADDR_W{1'b0}}];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    issuedCount <= issuedCount + 32'd1;
                    timer       <= '0;
                    state       <= WAIT;
                    if (stop) begin
                        stopPending <= 1'b1;
                    end
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (stop) begin
                        stopPending <= 1'b1;
                    end
                    if (endInstr) begin
                        if (timeoutHit) begin
                            timeoutFlag <= 1'b1;
                            if (timeoutCount != 16'hFFFF) begin
                                timeoutCount <= timeoutCount + 16'd1;
                            end
                        end
                        // A stop seen on the final WAIT cycle counts as already pending.
                        if (stopPending || stop) begin
                            state       <= IDLE;
                            stopPending <= 1'b0;
                        end else if (pc == lastAddr && !loopMode) begin
                            state <= DONE;
                        end else begin
                            pc          <= nextPc;
                            instruction <= mem[nextPc];
                            state       <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_issuer.sv
// tb/tb_instruction_issuer.sv - directed self-checking bench for instruction_issuer
module tb_instruction_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        loadEn;
    logic [3:0]  loadAddr;
    logic [31:0] loadData;
    logic        start;
    logic        stop;
    logic        loopMode;
    logic [3:0]  lastAddr;
    logic        completeInstruction;
    logic [31:0] instruction;
    logic        validInstruction;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [31:0] issuedCount;
    logic [15:0] timeoutCount;
    logic        timeoutFlag;

    localparam logic [31:0] P0 = 32'h002081B3;
    localparam logic [31:0] P1 = 32'h00310233;
    localparam logic [31:0] P2 = 32'h004182B3;
    localparam logic [31:0] P3 = 32'hDEADBEEF;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int coreCnt = 0;
    logic coreEn = 1'b1;

    int          vCyc[$];
    logic [3:0]  vPc[$];
    logic [31:0] vIns[$];
    logic        busyLog[int];
    int          doneCount;
    int          doneCyc;

    instruction_issuer #(.ADDR_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .loadEn(loadEn), .loadAddr(loadAddr),
        .loadData(loadData), .start(start), .stop(stop), .loopMode(loopMode),
        .lastAddr(lastAddr), .completeInstruction(completeInstruction),
        .instruction(instruction), .validInstruction(validInstruction),
        .busy(busy), .done(done), .pc(pc), .issuedCount(issuedCount),
        .timeoutCount(timeoutCount), .timeoutFlag(timeoutFlag)
    );

    always #5 clk = ~clk;

    // One clock; outputs sampled 1ns after the edge. The core model pulses
    // completeInstruction in the 4th cycle after each valid.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        completeInstruction = 1'b0;
        if (reset) begin
            coreCnt = 0;
        end else if (validInstruction) begin
            coreCnt = 4;
            vCyc.push_back(cyc);
            vPc.push_back(pc);
            vIns.push_back(instruction);
        end else if (coreCnt > 0) begin
            coreCnt--;
            if (coreCnt == 0 && coreEn) completeInstruction = 1'b1;
        end
        busyLog[cyc] = busy;
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
    endtask

    task automatic clearLog();
        vCyc.delete();
        vPc.delete();
        vIns.delete();
        doneCount = 0;
        doneCyc   = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (validInstruction !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", validInstruction); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %0b want 0", done); end
        total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc got %0d want 0", pc); end
        total++; if (instruction !== 32'd0) begin bad++; $display("FAIL reset_instr got %h want 0", instruction); end
        total++; if ({issuedCount, timeoutCount, timeoutFlag} !== 49'd0) begin bad++; $display("FAIL reset_counters got %0d/%0d/%0b want 0", issuedCount, timeoutCount, timeoutFlag); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        logic [31:0] words [4];
        words[0] = P0; words[1] = P1; words[2] = P2; words[3] = P3;
        for (int i = 0; i < 4; i++) begin
            loadEn = 1'b1; loadAddr = 4'(i); loadData = words[i];
            tick();
        end
        loadEn = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        int s;
        logic [31:0] exp [3];
        exp[0] = P0; exp[1] = P1; exp[2] = P2;
        clearLog();
        loopMode = 1'b0; lastAddr = 4'd2;
        s = cyc;
        start = 1'b1; tick(); start = 1'b0;
        repeat (24) tick();
        total++; if (vCyc.size() !== 3) begin bad++; $display("FAIL single_nvalid got %0d want 3", vCyc.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (vCyc[i] !== s + 1 + 5 * i) begin bad++; $display("FAIL single_vcyc%0d got %0d want %0d", i, vCyc[i] - s, 1 + 5 * i); end
            total++; if (vPc[i] !== 4'(i)) begin bad++; $display("FAIL single_pc%0d got %0d want %0d", i, vPc[i], i); end
            total++; if (vIns[i] !== exp[i]) begin bad++; $display("FAIL single_instr%0d got %h want %h", i, vIns[i], exp[i]); end
        end
        total++; if (doneCount !== 1) begin bad++; $display("FAIL single_donecount got %0d want 1", doneCount); end
        total++; if (doneCyc !== s + 16) begin bad++; $display("FAIL single_donecyc got %0d want 16", doneCyc - s); end
        total++; if (issuedCount !== 32'd3) begin bad++; $display("FAIL single_issued got %0d want 3", issuedCount); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got %0b want 0", busy); end
        total++; if (timeoutCount !== 16'd0) begin bad++; $display("FAIL single_timeouts got %0d want 0", timeoutCount); end
    endtask

    task automatic test_loop_and_stop();
        int s;
        int lowSeen;
        clearLog();
        loopMode = 1'b1; lastAddr = 4'd2;
        s = cyc;
        start = 1'b1; tick(); start = 1'b0;
        repeat (31) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (12) tick();
        total++; if (vCyc.size() !== 7) begin bad++; $display("FAIL loop_nvalid got %0d want 7", vCyc.size()); end
        for (int i = 0; i < 7; i++) begin
            total++; if (vPc[i] !== 4'(i % 3)) begin bad++; $display("FAIL loop_pc%0d got %0d want %0d", i, vPc[i], i % 3); end
        end
        lowSeen = 0;
        for (int c = s + 1; c <= s + 35; c++) if (busyLog[c] !== 1'b1) lowSeen++;
        total++; if (lowSeen !== 0) begin bad++; $display("FAIL loop_busy_low got %0d cycles want 0", lowSeen); end
        total++; if (busyLog[s + 36] !== 1'b0) begin bad++; $display("FAIL loop_stop_idle got %0b want 0", busyLog[s + 36]); end
        total++; if (doneCount !== 0) begin bad++; $display("FAIL loop_done got %0d want 0", doneCount); end
        total++; if (issuedCount !== 32'd10) begin bad++; $display("FAIL loop_issued got %0d want 10", issuedCount); end
    endtask

    task automatic test_timeout();
        int s;
        clearLog();
        loopMode = 1'b0; lastAddr = 4'd2;
        coreEn = 1'b0;
        s = cyc;
        start = 1'b1; tick(); start = 1'b0;
        repeat (16) tick();
        coreEn = 1'b1;
        repeat (20) tick();
        total++; if (vCyc.size() !== 3) begin bad++; $display("FAIL tmo_nvalid got %0d want 3", vCyc.size()); end
        total++; if (vCyc[1] - vCyc[0] !== 16) begin bad++; $display("FAIL tmo_gap got %0d want 16", vCyc[1] - vCyc[0]); end
        total++; if (vCyc[2] !== s + 22) begin bad++; $display("FAIL tmo_third got %0d want 22", vCyc[2] - s); end
        total++; if (vPc[1] !== 4'd1) begin bad++; $display("FAIL tmo_pc_adv got %0d want 1", vPc[1]); end
        total++; if (timeoutCount !== 16'd1) begin bad++; $display("FAIL tmo_count got %0d want 1", timeoutCount); end
        total++; if (timeoutFlag !== 1'b1) begin bad++; $display("FAIL tmo_flag got %0b want 1", timeoutFlag); end
        total++; if (doneCyc !== s + 27) begin bad++; $display("FAIL tmo_done got %0d want 27", doneCyc - s); end
        total++; if (issuedCount !== 32'd13) begin bad++; $display("FAIL tmo_issued got %0d want 13", issuedCount); end
    endtask

    task automatic test_stop();
        int s;
        clearLog();
        loopMode = 1'b0; lastAddr = 4'd2;
        s = cyc;
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (15) tick();
        total++; if (vCyc.size() !== 2) begin bad++; $display("FAIL stop_nvalid got %0d want 2", vCyc.size()); end
        total++; if (busyLog[s + 10] !== 1'b1) begin bad++; $display("FAIL stop_awaits got %0b want 1", busyLog[s + 10]); end
        total++; if (busyLog[s + 11] !== 1'b0) begin bad++; $display("FAIL stop_idle got %0b want 0", busyLog[s + 11]); end
        total++; if (doneCount !== 0) begin bad++; $display("FAIL stop_done got %0d want 0", doneCount); end
        total++; if (issuedCount !== 32'd15) begin bad++; $display("FAIL stop_issued got %0d want 15", issuedCount); end
    endtask

    task automatic test_start_stop_together();
        clearLog();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        repeat (6) tick();
        total++; if (vCyc.size() !== 0) begin bad++; $display("FAIL startstop_nvalid got %0d want 0", vCyc.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL startstop_busy got %0b want 0", busy); end
        total++; if (issuedCount !== 32'd15) begin bad++; $display("FAIL startstop_issued got %0d want 15", issuedCount); end
    endtask

    task automatic test_load_while_busy();
        clearLog();
        loopMode = 1'b0; lastAddr = 4'd2;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        loadEn = 1'b1; loadAddr = 4'd1; loadData = 32'hBADBAD00; tick(); loadEn = 1'b0;
        repeat (20) tick();
        total++; if (vIns[1] !== P1) begin bad++; $display("FAIL loadbusy_instr got %h want %h", vIns[1], P1); end
        total++; if (issuedCount !== 32'd18) begin bad++; $display("FAIL loadbusy_issued got %0d want 18", issuedCount); end
    endtask

    task automatic test_reset_in_wait();
        clearLog();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick();
        total++; if (busy !== 1'b0 || validInstruction !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstwait_status got %0b%0b%0b want 000", busy, validInstruction, done); end
        total++; if (pc !== 4'd0 || instruction !== 32'd0) begin bad++; $display("FAIL rstwait_pc_instr got %0d/%h want 0/0", pc, instruction); end
        total++; if ({issuedCount, timeoutCount, timeoutFlag} !== 49'd0) begin bad++; $display("FAIL rstwait_counters got %0d/%0d/%0b want 0", issuedCount, timeoutCount, timeoutFlag); end
        reset = 1'b0;
        tick();
        clearLog();
        start = 1'b1; tick(); start = 1'b0;
        total++; if (validInstruction !== 1'b1) begin bad++; $display("FAIL rstwait_restart_valid got %0b want 1", validInstruction); end
        total++; if (instruction !== P0) begin bad++; $display("FAIL rstwait_restart_instr got %h want %h", instruction, P0); end
        repeat (20) tick();
        total++; if (issuedCount !== 32'd3) begin bad++; $display("FAIL rstwait_rerun_issued got %0d want 3", issuedCount); end
    endtask

    initial begin
        reset = 1'b1; loadEn = 1'b0; loadAddr = '0; loadData = '0;
        start = 1'b0; stop = 1'b0; loopMode = 1'b0; lastAddr = 4'd2;
        completeInstruction = 1'b0;
        clearLog();
        test_reset();
        test_load();
        test_single_pass();
        test_loop_and_stop();
        test_timeout();
        test_stop();
        test_start_stop_together();
        test_load_while_busy();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
